// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder: s = x ^ y ^ z, c = majority(x, y, z).
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one full-adder cell, valid/ready in and out.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             cout_r;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign accept    = in_valid & in_ready;
    assign last      = (state == RUN) && (counter == LAST);
    assign sum       = sum_sh;
    assign cout      = cout_r;

    full_adder_cell u_fa (
        .x (a_sh[0]),
        .y (b_sh[0]),
        .z (carry),
        .s (fa_s),
        .c (fa_c)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Subtraction is A + ~B + 1, so the inversion and forced carry happen at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            cout_r  <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= sub ? ~b : b;
            carry   <= sub ? 1'b1 : cin;
            counter <= '0;
        end else if (state == RUN) begin
            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
            carry   <= fa_c;
            counter <= last ? '0 : counter + CNT_W'(1);
            if (last) cout_r <= fa_c;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // On the last cycle 'carry' is the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ovf_r <= 1'b0;
        else if (last) ovf_r <= carry ^ fa_c;
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Called 1 time unit after a rising edge with the DUT idle. Returns the
    // result once out_valid rises, then lets one more edge pass.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic sv,
                          output logic [7:0] s, output logic c,
                          output int lat, output int busy_cycles);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hxx; b = 8'hxx; cin = 1'bx; sub = 1'bx;
        lat = 0;
        busy_cycles = busy ? 1 : 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cycles++;
        end
        s = sum;
        c = cout;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #3;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== 8'h00 || cout !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b ov=%b busy=%b sum=%h cout=%b, want 1 0 0 00 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [7:0] s; logic c; int lat; int bc;
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, s, c, lat, bc);
        total++;
        if (s !== 8'h8D || c !== 1'b0) begin
            bad++;
            $display("FAIL add_5a_33: got sum=%h cout=%b, want 8d 0", s, c);
        end
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL latency: got %0d edges, want 8", lat);
        end
        total++;
        if (bc !== 8) begin
            bad++;
            $display("FAIL busy_cycles: got %0d, want 8", bc);
        end
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_transfer: got rdy=%b ov=%b, want 1 0", in_ready, out_valid);
        end
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, s, c, lat, bc);
        total++;
        if (s !== 8'h00 || c !== 1'b1) begin
            bad++;
            $display("FAIL add_ff_00_cin: got sum=%h cout=%b, want 00 1", s, c);
        end
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, s, c, lat, bc);
        total++;
        if (s !== 8'hFF || c !== 1'b1) begin
            bad++;
            $display("FAIL add_ff_ff_cin: got sum=%h cout=%b, want ff 1", s, c);
        end
    endtask

    task automatic test_sub();
        logic [7:0] s; logic c; int lat; int bc;
        for (int ci = 0; ci < 2; ci++) begin
            run_op(8'h10, 8'h01, ci[0], 1'b1, s, c, lat, bc);
            total++;
            if (s !== 8'h0F || c !== 1'b1) begin
                bad++;
                $display("FAIL sub_10_01 cin=%0d: got sum=%h cout=%b, want 0f 1", ci, s, c);
            end
            run_op(8'h00, 8'h01, ci[0], 1'b1, s, c, lat, bc);
            total++;
            if (s !== 8'hFF || c !== 1'b0) begin
                bad++;
                $display("FAIL sub_00_01 cin=%0d: got sum=%h cout=%b, want ff 0", ci, s, c);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t[2];
        int n = 0;
        int w = 0;
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 40 && n < 2; i++) begin
            if (in_ready) begin
                t[n] = i;
                n++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if (n !== 2 || t[1] - t[0] !== 10) begin
            bad++;
            $display("FAIL b2b_spacing: got accepts=%0d gap=%0d, want 2 10", n, t[1] - t[0]);
        end
        while (!out_valid && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        total++;
        if (out_valid !== 1'b1 || sum !== 8'h03 || cout !== 1'b0) begin
            bad++;
            $display("FAIL b2b_result: got ov=%b sum=%h cout=%b, want 1 03 0", out_valid, sum, cout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] s; logic c; int lat; int bc;
        int stable_bad = 0;
        out_ready = 1'b0;
        run_op(8'hC8, 8'h64, 1'b0, 1'b0, s, c, lat, bc);
        total++;
        if (s !== 8'h2C || c !== 1'b1) begin
            bad++;
            $display("FAIL bp_result: got sum=%h cout=%b, want 2c 1", s, c);
        end
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h2C || cout !== 1'b1)
                stable_bad++;
            @(posedge clk); #1;
        end
        total++;
        if (stable_bad !== 0) begin
            bad++;
            $display("FAIL bp_hold: got %0d unstable cycles, want 0", stable_bad);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got ov=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s; logic c; int lat; int bc;
        a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        total++;
        if (sum !== 8'h00 || cout !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_run_reset: got sum=%h cout=%b ov=%b busy=%b rdy=%b, want 00 0 0 0 1",
                     sum, cout, out_valid, busy, in_ready);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(8'h01, 8'h01, 1'b0, 1'b0, s, c, lat, bc);
        total++;
        if (s !== 8'h02 || c !== 1'b0 || lat !== 8) begin
            bad++;
            $display("FAIL after_reset_op: got sum=%h cout=%b lat=%0d, want 02 0 8", s, c, lat);
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [7:0] s; logic c; int lat; int bc;
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, s, c, lat, bc);
        total++;
        if (s !== 8'h80 || c !== 1'b0 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_7f_01: got sum=%h cout=%b ovf=%b, want 80 0 1", s, c, ovf);
        end
        run_op(8'h80, 8'h01, 1'b0, 1'b1, s, c, lat, bc);
        total++;
        if (s !== 8'h7F || ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_80_m01: got sum=%h ovf=%b, want 7f 1", s, ovf);
        end
        run_op(8'h05, 8'h03, 1'b0, 1'b0, s, c, lat, bc);
        total++;
        if (s !== 8'h08 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_05_03: got sum=%h ovf=%b, want 08 0", s, ovf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
